// File: rtl/bus_arbiter.sv
// Two-core, two-class (data/instruction) arbiter in front of one shared RAM port.
// Data beats instruction, round-robin within a class, and a wait-cycle timeout aborts a stuck grant.
module bus_arbiter #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned WORD_W  = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic [1:0]        dREN,
   input  logic [1:0]        dWEN,
   input  logic [WORD_W-1:0] daddr0,
   input  logic [WORD_W-1:0] daddr1,
   input  logic [WORD_W-1:0] dstore0,
   input  logic [WORD_W-1:0] dstore1,
   input  logic [1:0]        iREN,
   input  logic [WORD_W-1:0] iaddr0,
   input  logic [WORD_W-1:0] iaddr1,
   output logic [1:0]        dwait,
   output logic [1:0]        iwait,
   output logic [WORD_W-1:0] dload,
   output logic [WORD_W-1:0] iload,
   output logic [WORD_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   output logic              ramREN,
   output logic              ramWEN,
   input  logic [WORD_W-1:0] ramload,
   input  logic              ramwait,
   output logic [1:0]        grant_id,
   output logic              busy,
   output logic              err
);

   localparam int unsigned     CNT_W    = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         grant_q, grant_d;
   logic               dptr_q, dptr_d;
   logic               iptr_q, iptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;

   logic [1:0]         dreq;
   logic               own_cls;
   logic               own_core;
   logic               own_req;
   logic               win_valid;
   logic               win_cls;
   logic               win_core;
   logic [WORD_W-1:0]  own_daddr;
   logic [WORD_W-1:0]  own_dstore;
   logic [WORD_W-1:0]  own_iaddr;

   // Pointed core wins a tie, a lone requester always wins.
   function automatic logic pick(input logic [1:0] req, input logic ptr);
      return (req == 2'b11) ? ptr : req[1];
   endfunction

   assign dreq       = dREN | dWEN;
   assign own_cls    = grant_q[1];
   assign own_core   = grant_q[0];
   assign own_req    = own_cls ? dreq[own_core] : iREN[own_core];
   assign own_daddr  = own_core ? daddr1  : daddr0;
   assign own_dstore = own_core ? dstore1 : dstore0;
   assign own_iaddr  = own_core ? iaddr1  : iaddr0;

   always_comb begin
      win_valid = 1'b1;
      win_cls   = 1'b0;
      win_core  = 1'b0;
      if (|dreq) begin
         win_cls  = 1'b1;
         win_core = pick(dreq, dptr_q);
      end else if (|iREN) begin
         win_core = pick(iREN, iptr_q);
      end else begin
         win_valid = 1'b0;
      end
   end

   // State register and grant bookkeeping.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= IDLE;
         grant_q <= 2'b00;
         dptr_q  <= 1'b0;
         iptr_q  <= 1'b0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         dptr_q  <= dptr_d;
         iptr_q  <= iptr_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Next state: arbitrate only in IDLE; leave SERVE on completion, owner drop or timeout.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      dptr_d  = dptr_q;
      iptr_d  = iptr_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      if (state_q == IDLE) begin
         cnt_d = '0;
         if (win_valid) begin
            state_d = SERVE;
            grant_d = {win_cls, win_core};
         end
      end else begin
         if (!own_req) begin
            state_d = IDLE;
         end else if (!ramwait) begin
            state_d = IDLE;
            if (own_cls) begin
               dptr_d = ~dptr_q;
            end else begin
               iptr_d = ~iptr_q;
            end
         end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            err_d   = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // RAM side follows the owner's live inputs; reset forces the idle view.
   always_comb begin
      dwait    = 2'b11;
      iwait    = 2'b11;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      if (nRST && (state_q == SERVE)) begin
         if (own_cls) begin
            ramaddr  = own_daddr;
            ramstore = own_dstore;
            ramWEN   = dWEN[own_core];
            ramREN   = dREN[own_core] & ~dWEN[own_core];
            if (own_req && !ramwait) begin
               dwait[own_core] = 1'b0;
            end
         end else begin
            ramaddr = own_iaddr;
            ramREN  = iREN[own_core];
            if (own_req && !ramwait) begin
               iwait[own_core] = 1'b0;
            end
         end
      end
   end

   assign dload    = ramload;
   assign iload    = ramload;
   assign grant_id = grant_q;
   assign busy     = (state_q == SERVE);
   assign err      = err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios then randomized traffic, all checked
// cycle by cycle against a transaction-level reference of the arbitration rules.
module tb_bus_arbiter;

   localparam int unsigned TO = 4;
   localparam int unsigned W  = 32;

   logic          CLK = 1'b0;
   logic          nRST;
   logic [1:0]    dREN, dWEN, iREN;
   logic [W-1:0]  daddr0, daddr1, dstore0, dstore1, iaddr0, iaddr1;
   logic [1:0]    dwait, iwait;
   logic [W-1:0]  dload, iload, ramaddr, ramstore, ramload;
   logic          ramREN, ramWEN, ramwait;
   logic [1:0]    grant_id;
   logic          busy, err;

   int unsigned   ncmp = 0;
   int unsigned   nbad = 0;

   // Reference: is a grant open, who owns it, per-class pointer, wait cycles so far.
   bit            m_srv;
   int            m_cls, m_core, m_cnt;
   int            m_ptr [2];
   bit            m_err;
   logic [1:0]    m_gid;
   bit            m_done;
   int            m_dcls, m_dcore;

   bus_arbiter #(.TIMEOUT(TO), .WORD_W(W)) dut (
      .CLK(CLK), .nRST(nRST),
      .dREN(dREN), .dWEN(dWEN),
      .daddr0(daddr0), .daddr1(daddr1),
      .dstore0(dstore0), .dstore1(dstore1),
      .iREN(iREN), .iaddr0(iaddr0), .iaddr1(iaddr1),
      .dwait(dwait), .iwait(iwait),
      .dload(dload), .iload(iload),
      .ramaddr(ramaddr), .ramstore(ramstore),
      .ramREN(ramREN), .ramWEN(ramWEN),
      .ramload(ramload), .ramwait(ramwait),
      .grant_id(grant_id), .busy(busy), .err(err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nbad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit wants(input int cls, input int core);
      if (cls == 1) return (dREN[core] | dWEN[core]) == 1'b1;
      return iREN[core] == 1'b1;
   endfunction

   task automatic check_outputs();
      logic [1:0]   ed, ei;
      logic         er, ew;
      logic [W-1:0] ea, es;
      ed = 2'b11; ei = 2'b11; er = 1'b0; ew = 1'b0; ea = '0; es = '0;
      if (nRST && m_srv) begin
         if (m_cls == 1) begin
            ea = (m_core == 1) ? daddr1 : daddr0;
            es = (m_core == 1) ? dstore1 : dstore0;
            ew = dWEN[m_core];
            er = dREN[m_core] & ~dWEN[m_core];
            if (wants(1, m_core) && !ramwait) ed[m_core] = 1'b0;
         end else begin
            ea = (m_core == 1) ? iaddr1 : iaddr0;
            er = iREN[m_core];
            if (wants(0, m_core) && !ramwait) ei[m_core] = 1'b0;
         end
      end
      chk("dwait", 64'(dwait), 64'(ed));
      chk("iwait", 64'(iwait), 64'(ei));
      chk("ramREN", 64'(ramREN), 64'(er));
      chk("ramWEN", 64'(ramWEN), 64'(ew));
      chk("ramaddr", 64'(ramaddr), 64'(ea));
      chk("ramstore", 64'(ramstore), 64'(es));
      chk("dload", 64'(dload), 64'(ramload));
      chk("iload", 64'(iload), 64'(ramload));
      chk("grant_id", 64'(grant_id), 64'(m_gid));
      chk("busy", 64'(busy), 64'(m_srv));
      chk("err", 64'(err), 64'(m_err));
   endtask

   // Apply the arbitration rules for one rising edge.
   task automatic model_edge();
      bit found;
      m_done = 1'b0;
      if (!nRST) begin
         m_srv = 1'b0; m_ptr[0] = 0; m_ptr[1] = 0; m_cnt = 0; m_gid = 2'b00; m_err = 1'b0;
      end else if (m_srv) begin
         m_err = 1'b0;
         if (!wants(m_cls, m_core)) begin
            m_srv = 1'b0;
         end else if (!ramwait) begin
            m_ptr[m_cls] = 1 - m_ptr[m_cls];
            m_srv = 1'b0; m_done = 1'b1; m_dcls = m_cls; m_dcore = m_core;
         end else begin
            m_cnt++;
            if (m_cnt == int'(TO)) begin
               m_srv = 1'b0; m_err = 1'b1;
            end
         end
      end else begin
         m_err = 1'b0;
         found = 1'b0;
         for (int c = 1; c >= 0; c--) begin
            for (int k = 0; k < 2; k++) begin
               int core;
               core = (m_ptr[c] + k) % 2;
               if (!found && wants(c, core)) begin
                  found = 1'b1; m_cls = c; m_core = core;
               end
            end
         end
         if (found) begin
            m_srv = 1'b1; m_cnt = 0; m_gid = 2'(m_cls * 2 + m_core);
         end
      end
   endtask

   // Inputs are driven at posedge+1; outputs checked at posedge+3 or later.
   task automatic cyc();
      #2;
      check_outputs();
      @(posedge CLK);
      model_edge();
      #1;
   endtask

   initial begin
      int k, zeros;
      logic [1:0] order [4];
      order[0] = 2'b10; order[1] = 2'b11; order[2] = 2'b00; order[3] = 2'b01;

      nRST = 1'b0;
      dREN = 2'b11; dWEN = 2'b01; iREN = 2'b11;
      daddr0 = 32'h0000_1000; daddr1 = 32'h0000_2000;
      dstore0 = 32'h1111_1111; dstore1 = 32'h2222_2222;
      iaddr0 = 32'h0000_3000; iaddr1 = 32'h0000_4000;
      ramload = 32'hCAFE_0001; ramwait = 1'b0;
      @(posedge CLK);
      model_edge();
      #1;
      repeat (2) cyc();

      nRST = 1'b1; dREN = 2'b00; dWEN = 2'b00; iREN = 2'b00;
      repeat (2) cyc();

      // Both classes, both cores: order 10, 11, 00, 01; RAM stalls one cycle each.
      dREN = 2'b11; iREN = 2'b11; k = 0;
      for (int c = 0; c < 20 && !(k == 4 && !m_srv); c++) begin
         ramwait = (m_srv && m_cnt == 0);
         if (m_srv && m_cnt == 0 && k < 4) begin
            chk("rr_order", 64'(grant_id), 64'(order[k]));
            k++;
         end
         cyc();
         if (m_done) begin
            if (m_dcls == 1) dREN[m_dcore] = 1'b0;
            else iREN[m_dcore] = 1'b0;
         end
      end
      chk("rr_count", 64'(k), 64'd4);

      // Read+write together from core0 is a write.
      dREN = 2'b01; dWEN = 2'b01; iREN = 2'b00;
      daddr0 = 32'h0000_0100; dstore0 = 32'hDEAD_BEEF; ramwait = 1'b1;
      cyc();
      #1;
      chk("wr_ramWEN", 64'(ramWEN), 64'd1);
      chk("wr_ramREN", 64'(ramREN), 64'd0);
      chk("wr_ramaddr", 64'(ramaddr), 64'h100);
      chk("wr_ramstore", 64'(ramstore), 64'hDEAD_BEEF);
      cyc();
      ramwait = 1'b0;
      cyc();
      dREN = 2'b00; dWEN = 2'b00;
      cyc();

      // Timeout: instr core0 (iptr=0) aborted after TO stalled cycles, then wins again.
      iREN = 2'b11; ramwait = 1'b1;
      cyc();
      repeat (TO) cyc();
      #1;
      chk("to_err", 64'(err), 64'd1);
      chk("to_busy", 64'(busy), 64'd0);
      cyc();
      #1;
      chk("to_regrant", 64'(grant_id), 64'b00);
      chk("to_err_once", 64'(err), 64'd0);
      iREN = 2'b00;
      cyc();

      // Owner drops iREN[1] mid-grant.
      iREN = 2'b10; ramwait = 1'b1;
      cyc();
      cyc();
      iREN = 2'b00;
      #1;
      chk("drop_ramREN", 64'(ramREN), 64'd0);
      cyc();
      #1;
      chk("drop_busy", 64'(busy), 64'd0);
      chk("drop_err", 64'(err), 64'd0);
      iREN = 2'b11; ramwait = 1'b0;
      cyc();
      #1;
      chk("drop_iptr", 64'(grant_id), 64'b00);
      cyc();
      iREN = 2'b00;
      cyc();

      // Reset mid-grant with dptr=1.
      dREN = 2'b11; ramwait = 1'b1;
      cyc();
      #1;
      chk("rst_pre_gid", 64'(grant_id), 64'b11);
      nRST = 1'b0;
      #1;
      chk("rst_dwait", 64'(dwait), 64'b11);
      chk("rst_ramREN", 64'(ramREN), 64'd0);
      cyc();
      nRST = 1'b1;
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      cyc();
      #1;
      chk("rst_dptr", 64'(grant_id), 64'b10);
      ramwait = 1'b0;
      cyc();
      dREN = 2'b00;
      cyc();

      // Lone instr requester with fast RAM: served every second cycle.
      iREN = 2'b01; ramwait = 1'b0; zeros = 0;
      repeat (8) begin
         #1;
         if (iwait[0] == 1'b0) zeros++;
         cyc();
      end
      chk("alt_served", 64'(zeros), 64'd4);
      iREN = 2'b00;
      cyc();

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         nRST = ($urandom_range(0, 59) != 0);
         if ($urandom_range(0, 3) == 0) dREN = 2'($urandom);
         if ($urandom_range(0, 3) == 0) dWEN = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
         if ($urandom_range(0, 3) == 0) iREN = 2'($urandom);
         daddr0 = $urandom; daddr1 = $urandom; dstore0 = $urandom; dstore1 = $urandom;
         iaddr0 = $urandom; iaddr1 = $urandom; ramload = $urandom;
         ramwait = ($urandom_range(0, 3) != 0);
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end

endmodule
